// File: rtl/lsu_mem_port.sv
// lsu_mem_port: RV32I load/store initiator driving read port 2 and the byte-enable write port of ram.
// Build macro LSU_MISALIGN_SPLIT_EN: misaligned accesses become two word transactions instead of errors.
module lsu_mem_port #(
    parameter int MEM_WORDS = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [29:0] mem_r_addr,
    input  logic [31:0] mem_r_val,
    output logic        mem_w_enable,
    output logic [29:0] mem_w_addr,
    output logic [31:0] mem_w_val,
    output logic [3:0]  mem_byte_en
);
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif
    localparam logic [30:0] WORD_LIMIT = 31'(MEM_WORDS);

    typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_RDCAP, S_WR0, S_WR1, S_RESP} state_t;
    state_t r_state, w_next;

    logic [1:0]  w_off;
    logic [29:0] w_wa, w_wa1;
    logic [3:0]  w_smask;
    logic [7:0]  w_mask8;
    logic [63:0] w_data64;
    logic        w_mis, w_bad_f3, w_oor_lo, w_oor_hi, w_err;

    assign w_off    = req_addr[1:0];
    assign w_wa     = req_addr[31:2];
    assign w_wa1    = w_wa + 30'd1;
    assign w_mask8  = {4'b0000, w_smask} << w_off;
    assign w_data64 = {32'd0, req_wdata} << {w_off, 3'b000};
    // Any lane spilling into the upper word means o + size > 4.
    assign w_mis    = |w_mask8[7:4];
    assign w_bad_f3 = req_we ? (req_funct3 > 3'd2) : (req_funct3 == 3'd3 || req_funct3 > 3'd5);
    assign w_oor_lo = {1'b0, w_wa} >= WORD_LIMIT;
    assign w_oor_hi = {1'b0, w_wa1} >= WORD_LIMIT;
    assign w_err    = w_bad_f3 | w_oor_lo | (w_mis & (w_oor_hi | ~SPLIT_EN));

    always_comb begin
        w_smask = 4'b0000;
        case (req_funct3[1:0])
            2'd0:    w_smask = 4'b0001;
            2'd1:    w_smask = 4'b0011;
            2'd2:    w_smask = 4'b1111;
            default: w_smask = 4'b0000;
        endcase
    end

    logic [1:0]  r_off;
    logic [2:0]  r_f3;
    logic        r_split;
    logic [29:0] r_wa1;
    logic [3:0]  r_hi_mask;
    logic [31:0] r_hi_data, r_d0;

    // NOTE: payload registers carry no reset; they are only consumed in states entered after a fresh accept.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && req_valid) begin
            r_off     <= w_off;
            r_f3      <= req_funct3;
            r_split   <= w_mis;
            r_wa1     <= w_wa1;
            r_hi_mask <= w_mask8[7:4];
            r_hi_data <= w_data64[63:32];
        end
        if (r_state == S_RD1) r_d0 <= mem_r_val;
    end

    logic [63:0] w_pair;
    logic [31:0] w_word, w_load;

    assign w_pair = r_split ? {mem_r_val, r_d0} : {32'd0, mem_r_val};
    assign w_word = w_pair[6'({r_off, 3'b000}) +: 32];

    always_comb begin
        w_load = 32'd0;
        case (r_f3)
            3'd0:    w_load = {{24{w_word[7]}}, w_word[7:0]};
            3'd1:    w_load = {{16{w_word[15]}}, w_word[15:0]};
            3'd2:    w_load = w_word;
            3'd4:    w_load = {24'd0, w_word[7:0]};
            3'd5:    w_load = {16'd0, w_word[15:0]};
            default: w_load = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = w_err ? S_RESP : (req_we ? S_WR0 : S_RD0);
            S_RD0:   w_next = r_split ? S_RD1 : S_RDCAP;
            S_RD1:   w_next = S_RDCAP;
            S_RDCAP: w_next = S_RESP;
            S_WR0:   w_next = r_split ? S_WR1 : S_IDLE;
            S_WR1:   w_next = S_IDLE;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    logic        r_req_ready, r_resp_valid, r_resp_err, r_w_enable;
    logic [31:0] r_resp_rdata, r_w_val;
    logic [29:0] r_r_addr, r_w_addr;
    logic [3:0]  r_byte_en;
    logic        w_nx_ready, w_nx_resp_valid, w_nx_resp_err, w_nx_w_enable;
    logic [31:0] w_nx_resp_rdata, w_nx_w_val;
    logic [29:0] w_nx_r_addr, w_nx_w_addr;
    logic [3:0]  w_nx_byte_en;

    always_comb begin
        w_nx_ready      = (w_next == S_IDLE);
        w_nx_resp_valid = 1'b0;
        w_nx_resp_err   = 1'b0;
        w_nx_resp_rdata = 32'd0;
        w_nx_r_addr     = r_r_addr;
        w_nx_w_enable   = 1'b0;
        w_nx_w_addr     = r_w_addr;
        w_nx_w_val      = r_w_val;
        w_nx_byte_en    = 4'd0;
        case (r_state)
            S_IDLE: if (req_valid) begin
                if (w_err) begin
                    w_nx_resp_valid = 1'b1;
                    w_nx_resp_err   = 1'b1;
                end else if (req_we) begin
                    w_nx_w_enable   = 1'b1;
                    w_nx_w_addr     = w_wa;
                    w_nx_w_val      = w_data64[31:0];
                    w_nx_byte_en    = w_mask8[3:0];
                    w_nx_resp_valid = ~w_mis;
                end else begin
                    w_nx_r_addr = w_wa;
                end
            end
            S_RD0: if (r_split) w_nx_r_addr = r_wa1;
            S_RDCAP: begin
                w_nx_resp_valid = 1'b1;
                w_nx_resp_rdata = w_load;
            end
            S_WR0: if (r_split) begin
                w_nx_w_enable   = 1'b1;
                w_nx_w_addr     = r_wa1;
                w_nx_w_val      = r_hi_data;
                w_nx_byte_en    = r_hi_mask;
                w_nx_resp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_r_addr     <= 30'd0;
            r_w_enable   <= 1'b0;
            r_w_addr     <= 30'd0;
            r_w_val      <= 32'd0;
            r_byte_en    <= 4'd0;
        end else begin
            r_req_ready  <= w_nx_ready;
            r_resp_valid <= w_nx_resp_valid;
            r_resp_err   <= w_nx_resp_err;
            r_resp_rdata <= w_nx_resp_rdata;
            r_r_addr     <= w_nx_r_addr;
            r_w_enable   <= w_nx_w_enable;
            r_w_addr     <= w_nx_w_addr;
            r_w_val      <= w_nx_w_val;
            r_byte_en    <= w_nx_byte_en;
        end
    end

    // Reset squashes a write or response already registered for this cycle, so it never reaches the ram edge.
    assign req_ready    = r_req_ready;
    assign resp_valid   = r_resp_valid & ~rst;
    assign resp_err     = r_resp_err;
    assign resp_rdata   = r_resp_rdata;
    assign mem_r_addr   = r_r_addr;
    assign mem_w_enable = r_w_enable & ~rst;
    assign mem_w_addr   = r_w_addr;
    assign mem_w_val    = r_w_val;
    assign mem_byte_en  = r_byte_en & {4{~rst}};

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: randomized and directed stimulus for lsu_mem_port against a byte-level reference model.
// Honours LSU_MISALIGN_SPLIT_EN the same way the design does.
module tb_lsu_mem_port;
    localparam int MEM_WORDS = 500;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk, rst, req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [29:0] mem_r_addr, mem_w_addr;
    logic [31:0] mem_r_val, mem_w_val;
    logic        mem_w_enable;
    logic [3:0]  mem_byte_en;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    lsu_mem_port #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_r_addr(mem_r_addr), .mem_r_val(mem_r_val),
        .mem_w_enable(mem_w_enable), .mem_w_addr(mem_w_addr),
        .mem_w_val(mem_w_val), .mem_byte_en(mem_byte_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached ram: byte-enable write, registered read.
    always @(posedge clk) begin
        if (mem_w_enable && int'(mem_w_addr) < MEM_WORDS)
            for (int i = 0; i < 4; i++)
                if (mem_byte_en[i]) mem[int'(mem_w_addr)][8*i +: 8] <= mem_w_val[8*i +: 8];
        mem_r_val <= (int'(mem_r_addr) < MEM_WORDS) ? mem[int'(mem_r_addr)] : 32'hDEAD_BEEF;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input string tag);
        int o, size, wa, wa1, lat, nwr, n, resp_cyc, pulses, ready_cyc, bad_be, nobs;
        bit bad, mis, err;
        logic [31:0] exp_rd, got_rd;
        logic        got_err;
        logic [3:0]  be_lo, be_hi;
        int          obs_cyc [2];
        int          obs_addr [2];
        logic [3:0]  obs_be [2];
        o    = int'(addr[1:0]);
        wa   = int'(addr[31:2]);
        wa1  = (wa + 1) % (1 << 30);
        bad  = we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size = 1 << f3[1:0];
        mis  = (o + size) > 4;
        err  = bad || (wa >= MEM_WORDS) || (mis && (!SPLIT || wa1 >= MEM_WORDS));
        lat  = err ? 1 : (we ? (mis ? 2 : 1) : (mis ? 4 : 3));
        nwr  = (err || !we) ? 0 : (mis ? 2 : 1);
        exp_rd = 32'd0; be_lo = 4'd0; be_hi = 4'd0;
        if (!err) begin
            for (int i = 0; i < size; i++) begin
                int idx;
                int w;
                idx = o + i;
                w   = (idx < 4) ? wa : wa1;
                if (we) begin
                    ref_mem[w][8*(idx%4) +: 8] = wd[8*i +: 8];
                    if (idx < 4) be_lo[idx] = 1'b1;
                    else         be_hi[idx-4] = 1'b1;
                end else begin
                    exp_rd[8*i +: 8] = ref_mem[w][8*(idx%4) +: 8];
                end
            end
            if (!we && f3 == 3'd0 && exp_rd[7])  exp_rd[31:8]  = '1;
            if (!we && f3 == 3'd1 && exp_rd[15]) exp_rd[31:16] = '1;
        end

        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        n_assert++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s ready_wait: req_ready=%b want 1", tag, req_ready);
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;

        resp_cyc = 0; pulses = 0; ready_cyc = 0; bad_be = 0; nobs = 0; got_rd = 0; got_err = 0;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                pulses++;
                if (resp_cyc == 0) begin resp_cyc = k; got_rd = resp_rdata; got_err = resp_err; end
            end
            if (req_ready && ready_cyc == 0) ready_cyc = k;
            if (mem_w_enable) begin
                if (nobs < 2) begin
                    obs_cyc[nobs] = k; obs_addr[nobs] = int'(mem_w_addr); obs_be[nobs] = mem_byte_en;
                end
                nobs++;
            end else if (mem_byte_en != 4'd0) begin
                bad_be++;
            end
        end

        n_assert++;
        if (resp_cyc !== lat) begin n_fail++; $display("FAIL %s resp_latency: got %0d want %0d", tag, resp_cyc, lat); end
        n_assert++;
        if (pulses !== 1) begin n_fail++; $display("FAIL %s resp_pulses: got %0d want 1", tag, pulses); end
        n_assert++;
        if (got_err !== err) begin n_fail++; $display("FAIL %s resp_err: got %b want %b", tag, got_err, err); end
        n_assert++;
        if (got_rd !== exp_rd) begin n_fail++; $display("FAIL %s resp_rdata: got %h want %h", tag, got_rd, exp_rd); end
        n_assert++;
        if (ready_cyc !== lat + 1) begin n_fail++; $display("FAIL %s ready_return: got cycle %0d want %0d", tag, ready_cyc, lat + 1); end
        n_assert++;
        if (nobs !== nwr) begin n_fail++; $display("FAIL %s write_count: got %0d want %0d", tag, nobs, nwr); end
        n_assert++;
        if (bad_be !== 0) begin n_fail++; $display("FAIL %s byte_en_idle: got %0d cycles with lanes set want 0", tag, bad_be); end
        for (int j = 0; j < nwr && j < nobs; j++) begin
            n_assert++;
            if (obs_cyc[j] !== j + 1 || obs_addr[j] !== (j == 0 ? wa : wa1) || obs_be[j] !== (j == 0 ? be_lo : be_hi)) begin
                n_fail++;
                $display("FAIL %s write%0d: got cyc %0d addr %0d be %b want cyc %0d addr %0d be %b", tag, j,
                         obs_cyc[j], obs_addr[j], obs_be[j], j + 1, (j == 0 ? wa : wa1), (j == 0 ? be_lo : be_hi));
            end
        end
        if (we && wa < MEM_WORDS) begin
            n_assert++;
            if (mem[wa] !== ref_mem[wa]) begin n_fail++; $display("FAIL %s ram_lo: got %h want %h", tag, mem[wa], ref_mem[wa]); end
        end
        if (we && mis && wa1 < MEM_WORDS) begin
            n_assert++;
            if (mem[wa1] !== ref_mem[wa1]) begin n_fail++; $display("FAIL %s ram_hi: got %h want %h", tag, mem[wa1], ref_mem[wa1]); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_assert++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset ready: got %b want 1", req_ready); end
        n_assert++;
        if ({resp_valid, resp_err, resp_rdata, mem_r_addr, mem_w_enable, mem_w_addr, mem_w_val, mem_byte_en} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got rv %b err %b rd %h ra %h we %b wa %h wv %h be %b want all 0",
                     resp_valid, resp_err, resp_rdata, mem_r_addr, mem_w_enable, mem_w_addr, mem_w_val, mem_byte_en);
        end
        rst = 1'b0;
        @(negedge clk);
        n_assert++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset idle: got ready %b resp_valid %b want 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_aligned_load();
        run_req(1'b0, 3'd2, 32'd12, 32'd0, "lw_word3");
    endtask

    task automatic test_byte_half();
        run_req(1'b1, 3'd0, 32'h0D, 32'h0000_00F0, "sb_0d");
        run_req(1'b0, 3'd0, 32'h0D, 32'd0, "lb_0d");
        run_req(1'b0, 3'd4, 32'h0D, 32'd0, "lbu_0d");
        run_req(1'b1, 3'd1, 32'h0E, 32'h0000_1234, "sh_0e");
        run_req(1'b0, 3'd5, 32'h0E, 32'd0, "lhu_0e");
        run_req(1'b1, 3'd1, 32'h0E, 32'h0000_8001, "sh_0e_neg");
        run_req(1'b0, 3'd1, 32'h0E, 32'd0, "lh_0e");
    endtask

    task automatic test_errors();
        run_req(1'b0, 3'd2, 32'(4 * MEM_WORDS), 32'd0, "lw_oor");
        run_req(1'b0, 3'd3, 32'd0, 32'd0, "load_f3_3");
        run_req(1'b1, 3'd4, 32'd8, 32'h1122_3344, "store_f3_4");
        run_req(1'b0, 3'd2, 32'hFFFF_FFFC, 32'd0, "lw_top_word");
        run_req(1'b1, 3'd2, 32'(4 * (MEM_WORDS - 1) + 2), 32'h5566_7788, "sw_last_spill");
        run_req(1'b0, 3'd7, 32'h100, 32'd0, "load_f3_7");
    endtask

    task automatic test_misaligned();
        run_req(1'b1, 3'd2, 32'h0F, 32'hAABB_CCDD, "sw_0f");
        run_req(1'b0, 3'd2, 32'h0F, 32'd0, "lw_0f");
        run_req(1'b0, 3'd1, 32'h13, 32'd0, "lh_13");
        run_req(1'b1, 3'd1, 32'h2B, 32'h0000_BEEF, "sh_2b");
        run_req(1'b0, 3'd5, 32'h2B, 32'd0, "lhu_2b");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            a = 32'(40 + i) << 2;
            run_req(1'b1, 3'd2, a, $urandom, "b2b_sw");
            run_req(1'b0, 3'd2, a, 32'd0, "b2b_lw");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            int          word;
            logic [2:0]  f3;
            logic [31:0] a;
            bit          we;
            we = 1'($urandom);
            case ($urandom_range(0, 4))
                0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
            endcase
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
            case ($urandom_range(0, 9))
                0:       word = MEM_WORDS - 2 + int'($urandom_range(0, 3));
                1:       word = -1;
                default: word = int'($urandom_range(0, 31));
            endcase
            a = (word < 0) ? $urandom : ((32'(word) << 2) | 32'($urandom_range(0, 3)));
            run_req(we, f3, a, $urandom, "random");
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] old;
        int          pulses;
        // load interrupted while in RDCAP
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'd0;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_assert++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0) begin
            n_fail++; $display("FAIL rst_rdcap state: got ready %b rv %b rd %h want 1 0 0", req_ready, resp_valid, resp_rdata);
        end
        rst = 1'b0;
        pulses = 0;
        repeat (3) begin @(negedge clk); if (resp_valid) pulses++; end
        n_assert++;
        if (pulses !== 0) begin n_fail++; $display("FAIL rst_rdcap resp: got %0d pulses want 0", pulses); end

        // store interrupted in WR0 before its write edge
        old = ref_mem[6];
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'd24; req_wdata = ~old;
        @(posedge clk); #1; req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_assert++;
        if (mem_w_enable !== 1'b0 || mem_byte_en !== 4'd0 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_wr0 strobes: got we %b be %b rv %b want 0 0 0", mem_w_enable, mem_byte_en, resp_valid);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_assert++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_wr0 state: got ready %b rv %b want 1 0", req_ready, resp_valid);
        end
        n_assert++;
        if (mem[6] !== old) begin n_fail++; $display("FAIL rst_wr0 ram: got %h want %h", mem[6], old); end
        run_req(1'b0, 3'd2, 32'd24, 32'd0, "lw_after_rst");
    endtask

    initial begin
        logic [31:0] tmp;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            tmp = (i == 3) ? 32'h8899_AABB : $urandom;
            mem[i] <= tmp;
            ref_mem[i] = tmp;
        end
        test_reset();
        test_aligned_load();
        test_byte_half();
        test_errors();
        test_misaligned();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
